// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute stage:
//   op_e        - 3-bit instruction opcode encoding
//   ex_state_e  - execute-stage FSM states (IDLE / MUL)
//   MUL_ITER    - number of shift-add iterations for a 32-bit multiply
//   CNT_W       - width of the multiply iteration counter
//   alu_result  - single-cycle result for every opcode except MUL
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MUL  = 3'b100,
      OP_ADDI = 3'b101,
      OP_LW   = 3'b110,
      OP_SW   = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_e;

   localparam int MUL_ITER = 32;
   localparam int CNT_W    = $clog2(MUL_ITER);

   // Wrap-around arithmetic; no overflow indication is produced.
   // ADDI/LW/SW all compute an address-style rs1 + imm.
   function automatic logic [31:0] alu_result(input op_e         op,
                                              input logic [31:0] rs1,
                                              input logic [31:0] rs2,
                                              input logic [31:0] imm);
      logic [31:0] res;
      case (op)
         OP_AND:  res = rs1 & rs2;
         OP_OR:   res = rs1 | rs2;
         OP_ADD:  res = rs1 + rs2;
         OP_SUB:  res = rs1 - rs2;
         default: res = rs1 + imm;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier datapath, one multiplier bit per step.
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   i_start           - load operands, clear accumulator and counter
//   i_step            - perform one shift-add iteration
//   i_flush           - abandon any operation, clear all state
//   i_multiplicand    - first operand (captured on i_start)
//   i_multiplier      - second operand (captured on i_start)
//   o_done            - the iteration about to happen is the last one
//   o_product         - accumulator including the current iteration; valid
//                       as the final product while o_done is high
// -----------------------------------------------------------------------------
module mul_iter
   import cpu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_start,
   input  logic        i_step,
   input  logic        i_flush,
   input  logic [31:0] i_multiplicand,
   input  logic [31:0] i_multiplier,
   output logic        o_done,
   output logic [31:0] o_product
);

   logic [31:0]      r_acc;
   logic [31:0]      r_mcand;
   logic [31:0]      r_mplier;
   logic [CNT_W-1:0] r_cnt;

   logic [31:0] w_addend;
   logic [31:0] w_acc_next;

   // Only the low 32 bits of the product are kept, so the multiplicand may
   // shift out of the top; that low word is identical for signed operands.
   assign w_addend   = r_mplier[0] ? r_mcand : 32'd0;
   assign w_acc_next = r_acc + w_addend;

   // The final iteration's add is folded in combinationally so the product
   // can be registered by the consumer on the same edge as that iteration.
   assign o_product = w_acc_next;
   assign o_done    = (r_cnt == CNT_W'(MUL_ITER - 1));

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values; blocking here would chain the updates.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (i_flush) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_mcand  <= i_multiplicand;
         r_mplier <= i_multiplier;
         r_cnt    <= '0;
      end else if (i_step) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Pipeline execute stage. Single-cycle ALU ops and address generation
// complete in one edge; MUL runs 32 shift-add iterations while stalling
// upstream.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   valid_i, op_i           - instruction valid and opcode from ID/EX
//   rs1_data_i, rs2_data_i  - register operands
//   imm_i, rsd_i            - immediate and destination register index
//   flush_i                 - kill the instruction in EX at the next edge
//   stall_o                 - combinational; upstream holds while high
//   valid_o, result_o       - registered EX/MEM valid and result
//   store_data_o, rsd_o     - registered store data and destination index
//   reg_wr_o, mem_rd_o,
//   mem_wr_o                - registered writeback / load / store controls
// -----------------------------------------------------------------------------
module ex_stage
   import cpu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rsd_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic [31:0] store_data_o,
   output logic [4:0]  rsd_o,
   output logic        reg_wr_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o
);

   ex_state_e r_state;
   ex_state_e w_state_next;

   op_e         w_op;
   logic        w_mul_start;
   logic        w_mul_step;
   logic        w_mul_done;
   logic [31:0] w_mul_product;

   // MUL bookkeeping carried from issue to completion.
   logic [4:0]  r_mul_rsd;
   logic [31:0] r_mul_rs2;

   logic        r_valid;
   logic [31:0] r_result;
   logic [31:0] r_store;
   logic [4:0]  r_rsd;
   logic        r_reg_wr;
   logic        r_mem_rd;
   logic        r_mem_wr;

   assign w_op = op_e'(op_i);

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_mul_start  = 1'b0;
      w_mul_step   = 1'b0;
      if (flush_i) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i && w_op == OP_MUL) begin
                  w_mul_start  = 1'b1;
                  w_state_next = ST_MUL;
               end
            end
            ST_MUL: begin
               w_mul_step = 1'b1;
               if (w_mul_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // Stall covers the MUL issue cycle and all but the last iteration; in the
   // last iteration upstream may advance because EX will be free next edge.
   assign stall_o = !rst_i && !flush_i &&
                    (((r_state == ST_IDLE) && valid_i && (w_op == OP_MUL)) ||
                     ((r_state == ST_MUL) && !w_mul_done));

   mul_iter u_mul_iter (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .i_start        (w_mul_start),
      .i_step         (w_mul_step),
      .i_flush        (flush_i),
      .i_multiplicand (rs1_data_i),
      .i_multiplier   (rs2_data_i),
      .o_done         (w_mul_done),
      .o_product      (w_mul_product)
   );

   // ---------------------------------------------------------------------
   // EX/MEM output register. Bubbles clear the control bits and leave the
   // data fields holding their last value.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid   <= 1'b0;
         r_result  <= '0;
         r_store   <= '0;
         r_rsd     <= '0;
         r_reg_wr  <= 1'b0;
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_mul_rsd <= '0;
         r_mul_rs2 <= '0;
      end else begin
         r_valid  <= 1'b0;
         r_reg_wr <= 1'b0;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
         if (!flush_i) begin
            if (r_state == ST_MUL) begin
               // Inputs are ignored while iterating; only completion writes.
               if (w_mul_done) begin
                  r_valid  <= 1'b1;
                  r_result <= w_mul_product;
                  r_store  <= r_mul_rs2;
                  r_rsd    <= r_mul_rsd;
                  r_reg_wr <= 1'b1;
               end
            end else if (valid_i) begin
               if (w_op == OP_MUL) begin
                  r_mul_rsd <= rsd_i;
                  r_mul_rs2 <= rs2_data_i;
               end else begin
                  r_valid  <= 1'b1;
                  r_result <= alu_result(w_op, rs1_data_i, rs2_data_i, imm_i);
                  r_store  <= rs2_data_i;
                  r_rsd    <= rsd_i;
                  r_reg_wr <= (w_op != OP_SW);
                  r_mem_rd <= (w_op == OP_LW);
                  r_mem_wr <= (w_op == OP_SW);
               end
            end
         end
      end
   end

   assign valid_o      = r_valid;
   assign result_o     = r_result;
   assign store_data_o = r_store;
   assign rsd_o        = r_rsd;
   assign reg_wr_o     = r_reg_wr;
   assign mem_rd_o     = r_mem_rd;
   assign mem_wr_o     = r_mem_wr;

endmodule
